// File: rtl/uart_loader_pkg.sv
// Shared definitions for the SPC image UART loader: frame FSM encoding,
// protocol bytes, the write payload type and the baud divisor helper.
package uart_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 17;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_SYNC = 4'd1;
  localparam logic [3:0] ST_LEN0 = 4'd2;
  localparam logic [3:0] ST_LEN1 = 4'd3;
  localparam logic [3:0] ST_LEN2 = 4'd4;
  localparam logic [3:0] ST_DATA = 4'd5;
  localparam logic [3:0] ST_CSUM = 4'd6;
  localparam logic [3:0] ST_DONE = 4'd7;
  localparam logic [3:0] ST_FAIL = 4'd8;

  localparam logic [7:0] SYNC_BYTE = 8'h53;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } spc_wr_t;

  // Rounded clock cycles per UART bit
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch reject,
// one-cycle valid strobe the cycle after the stop-bit sample.
module uart_rx #(
  parameter int unsigned DIV = 215
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned TMR_W = $clog2(DIV);
  localparam int unsigned HALF  = DIV / 2;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rxd_meta, rxd_sync, rxd_prev;
  logic [1:0]       state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shreg, shreg_next;
  logic             valid_next, frame_err_next;

  assign data = shreg;

  // Synchronizer plus edge-detect history, idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    timer_next     = timer + TMR_W'(1);
    bit_cnt_next   = bit_cnt;
    shreg_next     = shreg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_next = '0;
        if (rxd_prev && !rxd_sync) state_next = RX_START;
      end
      RX_START: begin
        if (timer == TMR_W'(HALF - 1)) begin
          timer_next   = '0;
          bit_cnt_next = '0;
          state_next   = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer == TMR_W'(DIV - 1)) begin
          timer_next   = '0;
          shreg_next   = {rxd_sync, shreg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = RX_STOP;
        end
      end
      default: begin
        if (timer == TMR_W'(DIV - 1)) begin
          valid_next     = rxd_sync;
          frame_err_next = !rxd_sync;
          state_next     = RX_IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/uart_spc_loader.sv
// UART loader for an SPC/ARAM image: 'S', 17-bit length, payload, checksum.
// Define UART_LOADER_ACK_EN to send ACK/NAK on uart_txd at frame end.
module uart_spc_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 24_750_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned GAP_TIMEOUT = 24_750_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [7:0]  dout,
  output logic [16:0] addr,
  output logic        dout_valid,
  output logic        done,
  output logic        fail
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (uart_rxd),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  logic [3:0]        state, state_next;
  logic [ADDR_W-1:0] length, length_next;
  logic [7:0]        csum, csum_next;
  logic [GAP_W-1:0]  gap_cnt, gap_next;
  spc_wr_t           wr_q, wr_next;
  logic              dout_valid_next, done_next, fail_next;
  logic              in_frame;

  assign dout = wr_q.data;
  assign addr = wr_q.addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      length     <= '0;
      csum       <= '0;
      gap_cnt    <= '0;
      wr_q       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_next;
      length     <= length_next;
      csum       <= csum_next;
      gap_cnt    <= gap_next;
      wr_q       <= wr_next;
      dout_valid <= dout_valid_next;
      done       <= done_next;
      fail       <= fail_next;
    end
  end

  // Offset advances the cycle after its strobe so addr qualifies dout
  always_comb begin
    state_next      = state;
    length_next     = length;
    csum_next       = csum;
    gap_next        = '0;
    wr_next         = wr_q;
    dout_valid_next = 1'b0;
    in_frame        = (state >= ST_LEN0) && (state <= ST_CSUM);

    if (start) begin
      state_next  = ST_SYNC;
      length_next = '0;
      csum_next   = '0;
      wr_next     = '0;
    end else begin
      if (in_frame) gap_next = gap_cnt + GAP_W'(1);
      if (dout_valid) begin
        wr_next.addr = wr_q.addr + ADDR_W'(1);
        if (wr_q.addr + ADDR_W'(1) == length) state_next = ST_CSUM;
      end
      if (in_frame && (rx_ferr || gap_cnt == GAP_W'(GAP_TIMEOUT))) begin
        state_next = ST_FAIL;
      end else if (rx_valid) begin
        gap_next = '0;
        case (state)
          ST_SYNC: if (rx_data == SYNC_BYTE) state_next = ST_LEN0;
          ST_LEN0: begin
            length_next[7:0] = rx_data;
            state_next       = ST_LEN1;
          end
          ST_LEN1: begin
            length_next[15:8] = rx_data;
            state_next        = ST_LEN2;
          end
          ST_LEN2: begin
            length_next[16] = rx_data[0];
            if (rx_data[7:1] != 7'd0 || {rx_data[0], length[15:0]} == 17'd0)
              state_next = ST_FAIL;
            else
              state_next = ST_DATA;
          end
          ST_DATA: begin
            wr_next.data    = rx_data;
            dout_valid_next = 1'b1;
            csum_next       = csum + rx_data;
          end
          ST_CSUM: state_next = (rx_data == csum) ? ST_DONE : ST_FAIL;
          default: ;
        endcase
      end
    end

    done_next = (state_next == ST_DONE);
    fail_next = (state_next == ST_FAIL);
  end

`ifdef UART_LOADER_ACK_EN
  localparam int unsigned TMR_W = $clog2(DIV);

  logic             tx_active, tx_active_next;
  logic [9:0]       tx_shreg, tx_shreg_next;
  logic [3:0]       tx_cnt, tx_cnt_next;
  logic [TMR_W-1:0] tx_timer, tx_timer_next;
  logic             txd_next, ack_fire;

  assign ack_fire = (state_next == ST_DONE && state != ST_DONE) ||
                    (state_next == ST_FAIL && state != ST_FAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_active <= 1'b0;
      tx_shreg  <= '1;
      tx_cnt    <= '0;
      tx_timer  <= '0;
      uart_txd  <= 1'b1;
    end else begin
      tx_active <= tx_active_next;
      tx_shreg  <= tx_shreg_next;
      tx_cnt    <= tx_cnt_next;
      tx_timer  <= tx_timer_next;
      uart_txd  <= txd_next;
    end
  end

  // Acknowledge runs to completion regardless of start
  always_comb begin
    tx_active_next = tx_active;
    tx_shreg_next  = tx_shreg;
    tx_cnt_next    = tx_cnt;
    tx_timer_next  = tx_timer;
    txd_next       = 1'b1;
    if (!tx_active) begin
      if (ack_fire) begin
        tx_active_next = 1'b1;
        tx_shreg_next  = {1'b1, (state_next == ST_DONE) ? ACK : NAK, 1'b0};
        tx_cnt_next    = '0;
        tx_timer_next  = '0;
      end
    end else begin
      txd_next = tx_shreg[0];
      if (tx_timer == TMR_W'(DIV - 1)) begin
        tx_timer_next = '0;
        tx_shreg_next = {1'b1, tx_shreg[9:1]};
        tx_cnt_next   = tx_cnt + 4'd1;
        if (tx_cnt == 4'd9) begin
          tx_active_next = 1'b0;
          txd_next       = 1'b1;
        end
      end else begin
        tx_timer_next = tx_timer + TMR_W'(1);
      end
    end
  end
`else
  assign uart_txd = 1'b1;
`endif

endmodule

// File: tb/tb_uart_spc_loader.sv
// Directed bench for uart_spc_loader at 16 clocks per bit; checks ACK/NAK
// only when UART_LOADER_ACK_EN is defined.
module tb_uart_spc_loader;

  localparam int unsigned DIV = 16;
  localparam int unsigned GAP = 400;

  logic        clk = 1'b0;
  logic        reset, start, uart_rxd, uart_txd;
  logic [7:0]  dout;
  logic [16:0] addr;
  logic        dout_valid, done, fail;

  int tests_run = 0;
  int tests_failed = 0;

  logic [24:0] strb_q[$];
  logic [7:0]  ack_q[$];

  uart_spc_loader #(
    .CLK_FREQ    (1_600_000),
    .BAUD        (100_000),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .dout       (dout),
    .addr       (addr),
    .dout_valid (dout_valid),
    .done       (done),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dout_valid === 1'b1) strb_q.push_back({addr, dout});

`ifdef UART_LOADER_ACK_EN
  initial forever begin
    logic [7:0] b;
    @(negedge uart_txd);
    repeat (DIV / 2) @(negedge clk);
    if (uart_txd === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      ack_q.push_back(b);
    end
  end
`endif

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = ~bad_stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    send_byte(8'h53, 1'b0);
    send_byte(l0, 1'b0);
    send_byte(l1, 1'b0);
    send_byte(l2, 1'b0);
  endtask

  task automatic pulse_start();
    strb_q.delete();
    ack_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout got %h want 00", dout); end
    tests_run++; if (addr !== 17'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", addr); end
    tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    tests_run++; if ({done, fail} !== 2'b00) begin tests_failed++; $display("FAIL reset_done_fail got %b want 00", {done, fail}); end
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b want 1", uart_txd); end
  endtask

  task automatic test_good_frame();
    logic [24:0] exp_s [3];
    exp_s = '{{17'd0, 8'hAA}, {17'd1, 8'h55}, {17'd2, 8'h01}};
    pulse_start();
    send_hdr(8'h03, 8'h00, 8'h00);
    send_byte(8'hAA, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    tests_run++; if (strb_q.size() !== 3) begin tests_failed++; $display("FAIL good_count got %0d want 3", strb_q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= strb_q.size() || strb_q[i] !== exp_s[i]) begin
        tests_failed++; $display("FAIL good_strobe%0d got %h want %h", i, (i < strb_q.size()) ? strb_q[i] : 25'h0, exp_s[i]);
      end
    end
    tests_run++; if ({done, fail} !== 2'b10) begin tests_failed++; $display("FAIL good_done got %b want 10", {done, fail}); end
    repeat (200) @(negedge clk);
`ifdef UART_LOADER_ACK_EN
    tests_run++; if (ack_q.size() !== 1 || ack_q[0] !== 8'h06) begin tests_failed++; $display("FAIL good_ack got n=%0d want one 06", ack_q.size()); end
`else
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL good_txd got %b want 1", uart_txd); end
`endif
  endtask

  task automatic test_bad_csum();
    pulse_start();
    send_hdr(8'h03, 8'h00, 8'h00);
    send_byte(8'hAA, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    tests_run++; if ({done, fail} !== 2'b01) begin tests_failed++; $display("FAIL csum_fail got %b want 01", {done, fail}); end
    tests_run++; if (strb_q.size() !== 3) begin tests_failed++; $display("FAIL csum_count got %0d want 3", strb_q.size()); end
    send_byte(8'h00, 1'b0);
    tests_run++; if ({done, fail} !== 2'b01) begin tests_failed++; $display("FAIL csum_hold got %b want 01", {done, fail}); end
    repeat (200) @(negedge clk);
`ifdef UART_LOADER_ACK_EN
    tests_run++; if (ack_q.size() !== 1 || ack_q[0] !== 8'h15) begin tests_failed++; $display("FAIL csum_nak got n=%0d want one 15", ack_q.size()); end
`endif
  endtask

  task automatic test_sync_discard();
    pulse_start();
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_hdr(8'h01, 8'h00, 8'h00);
    send_byte(8'h7E, 1'b0); send_byte(8'h7E, 1'b0);
    repeat (4) @(negedge clk);
    tests_run++; if (strb_q.size() !== 1) begin tests_failed++; $display("FAIL sync_count got %0d want 1", strb_q.size()); end
    tests_run++; if (strb_q.size() < 1 || strb_q[0] !== {17'd0, 8'h7E}) begin tests_failed++; $display("FAIL sync_strobe got %h want 0007e", (strb_q.size() > 0) ? strb_q[0] : 25'h0); end
    tests_run++; if ({done, fail} !== 2'b10) begin tests_failed++; $display("FAIL sync_done got %b want 10", {done, fail}); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_bad_length();
    pulse_start();
    send_hdr(8'h00, 8'h00, 8'h00);
    tests_run++; if ({done, fail} !== 2'b01 || strb_q.size() !== 0) begin tests_failed++; $display("FAIL len_zero got df=%b n=%0d want 01 0", {done, fail}, strb_q.size()); end
    repeat (200) @(negedge clk);
    pulse_start();
    tests_run++; if ({done, fail} !== 2'b00) begin tests_failed++; $display("FAIL start_clear got %b want 00", {done, fail}); end
    send_hdr(8'h01, 8'h00, 8'h02);
    tests_run++; if ({done, fail} !== 2'b01) begin tests_failed++; $display("FAIL len2_bits got %b want 01", {done, fail}); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_glitch_framing();
    pulse_start();
    send_hdr(8'h01, 8'h00, 8'h00);
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk);
    tests_run++; if (strb_q.size() !== 0 || fail !== 1'b0) begin tests_failed++; $display("FAIL glitch got n=%0d fail=%b want 0 0", strb_q.size(), fail); end
    send_byte(8'h5A, 1'b0); send_byte(8'h5A, 1'b0);
    tests_run++; if (strb_q.size() !== 1 || done !== 1'b1) begin tests_failed++; $display("FAIL glitch_after got n=%0d done=%b want 1 1", strb_q.size(), done); end
    repeat (200) @(negedge clk);
    pulse_start();
    send_hdr(8'h02, 8'h00, 8'h00);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    tests_run++; if ({done, fail} !== 2'b01 || strb_q.size() !== 1) begin tests_failed++; $display("FAIL framing got df=%b n=%0d want 01 1", {done, fail}, strb_q.size()); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_gap_timeout();
    pulse_start();
    send_hdr(8'h03, 8'h00, 8'h00);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    tests_run++; if (fail !== 1'b0) begin tests_failed++; $display("FAIL gap_early got %b want 0", fail); end
    repeat (GAP + 50) @(negedge clk);
    tests_run++; if ({done, fail} !== 2'b01 || strb_q.size() !== 2) begin tests_failed++; $display("FAIL gap_timeout got df=%b n=%0d want 01 2", {done, fail}, strb_q.size()); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_restart();
    pulse_start();
    send_hdr(8'h04, 8'h00, 8'h00);
    send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
    tests_run++; if (addr !== 17'd2) begin tests_failed++; $display("FAIL restart_pre got %h want 2", addr); end
    pulse_start();
    tests_run++; if (addr !== 17'd0 || {done, fail} !== 2'b00) begin tests_failed++; $display("FAIL restart_clear got addr=%h df=%b want 0 00", addr, {done, fail}); end
    send_hdr(8'h01, 8'h00, 8'h00);
    send_byte(8'h33, 1'b0); send_byte(8'h33, 1'b0);
    tests_run++; if (strb_q.size() !== 1 || strb_q[0] !== {17'd0, 8'h33} || done !== 1'b1) begin tests_failed++; $display("FAIL restart_frame got n=%0d done=%b want 1 1", strb_q.size(), done); end
    repeat (200) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_hdr(8'h04, 8'h00, 8'h00);
    send_byte(8'h10, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if ({dout, addr, dout_valid, done, fail, uart_txd} !== {8'h00, 17'h0, 4'b0001}) begin
      tests_failed++; $display("FAIL reset_mid got dout=%h addr=%h v=%b d=%b f=%b tx=%b", dout, addr, dout_valid, done, fail, uart_txd);
    end
    send_byte(8'h20, 1'b0);
    tests_run++; if (strb_q.size() !== 1 || dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_strobe got n=%0d want 1", strb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_sync_discard();
    test_bad_length();
    test_glitch_framing();
    test_gap_timeout();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
